// File: rtl/axi_dram_rd_slave.sv
// AXI read-only slave serving bursts from a preloadable word memory, with a fixed latency and an address queue.
// Optional WRAP burst support is enabled by defining AXI_RD_WRAP_BURST_EN.
module axi_dram_rd_slave #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 1024,
  parameter int OST   = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AW-1:0]            araddr,
  input  logic [7:0]               arlen,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DW-1:0]            rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DW-1:0]            ld_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int OB = $clog2(DW / 8);
  localparam int PW = $clog2(OST);
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [IW-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   mem [DEPTH];
  logic [IW-1:0]   q_idx [OST];
  logic [7:0]      q_len [OST];
  logic [1:0]      q_burst [OST];
  logic [PW:0]     wptr, rptr;
  logic            rdy_q, full, empty, push, pop, hs;
  logic [AW-1:0]   ar_word;
  logic            unused_ok;
  logic [IW-1:0]   head_idx, cur_idx, nxt_idx, load_idx;
  logic [7:0]      head_len, cur_len, beat;
  logic [1:0]      head_burst, cur_burst;
  logic            head_err, cur_err, load, load_err, load_last;
  logic [3:0]      cnt;

  // Bursts that cannot be served return SLVERR with zero data on every beat.
  function automatic logic burst_err(input logic [1:0] b, input logic [7:0] len);
`ifdef AXI_RD_WRAP_BURST_EN
    return (b == 2'd3) ||
           ((b == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
`else
    return b[1] || (len != len);
`endif
  endfunction

  assign ar_word   = araddr >> OB;
  assign unused_ok = ^{araddr[OB-1:0], ar_word[AW-1:IW]};

  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign empty = (wptr == rptr);
  assign pop   = (state == IDLE) && !empty;
  assign arready = rdy_q && (!full || pop);
  assign push  = arvalid && arready;
  assign rvalid = (state == BURST);
  assign hs    = rvalid && rready;

  assign head_idx   = q_idx[rptr[PW-1:0]];
  assign head_len   = q_len[rptr[PW-1:0]];
  assign head_burst = q_burst[rptr[PW-1:0]];
  assign head_err   = burst_err(head_burst, head_len);

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (push) begin
      q_idx[wptr[PW-1:0]]   <= ar_word[IW-1:0];
      q_len[wptr[PW-1:0]]   <= arlen;
      q_burst[wptr[PW-1:0]] <= arburst;
    end
  end

  // Address of the following beat; WRAP stays inside an (arlen+1)-word aligned window.
  always_comb begin
    nxt_idx = cur_idx + IDX_ONE;
    case (cur_burst)
      2'd0: nxt_idx = cur_idx;
`ifdef AXI_RD_WRAP_BURST_EN
      2'd2: nxt_idx = (cur_idx & ~IW'(cur_len)) | ((cur_idx + IDX_ONE) & IW'(cur_len));
`endif
      default: nxt_idx = cur_idx + IDX_ONE;
    endcase
  end

  // Next state plus the beat-register load that prepares rdata for the upcoming beat.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_idx  = cur_idx;
    load_err  = cur_err;
    load_last = (cur_len == 8'd0);
    case (state)
      IDLE: if (!empty) begin
        if (LAT == 0) begin
          state_nx  = BURST;
          load      = 1'b1;
          load_idx  = head_idx;
          load_err  = head_err;
          load_last = (head_len == 8'd0);
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt <= 4'd1) begin
        state_nx = BURST;
        load     = 1'b1;
      end
      BURST: if (hs) begin
        if (rlast) begin
          state_nx = IDLE;
        end else begin
          load      = 1'b1;
          load_idx  = nxt_idx;
          load_last = (8'(beat + 8'd1) == cur_len);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      cur_idx   <= '0;
      cur_len   <= '0;
      cur_burst <= '0;
      cur_err   <= 1'b0;
      beat      <= '0;
      rdata     <= '0;
      rresp     <= '0;
      rlast     <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) begin
        rptr      <= rptr + PTR_ONE;
        cur_idx   <= head_idx;
        cur_len   <= head_len;
        cur_burst <= head_burst;
        cur_err   <= head_err;
        cnt       <= 4'(LAT);
        beat      <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (hs) begin
        beat    <= beat + 8'd1;
        cur_idx <= nxt_idx;
      end
      if (load) begin
        rdata <= load_err ? '0 : mem[load_idx];
        rresp <= load_err ? 2'd2 : 2'd0;
        rlast <= load_last;
      end else if (hs && rlast) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_dram_rd_slave.sv
// Directed self-checking bench for axi_dram_rd_slave with default parameters (LAT=2, DEPTH=1024, DW=32).
// WRAP expectations follow AXI_RD_WRAP_BURST_EN when it is defined for the build.
module tb_axi_dram_rd_slave;

  logic        clk, rst_n;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready, rvalid, rready, rlast, ld_en;
  logic [31:0] rdata, ld_data;
  logic [1:0]  rresp;
  logic [9:0]  ld_addr;
  int          nChecks = 0;
  int          nFails  = 0;

  axi_dram_rd_slave dut (
    .clk(clk), .rst_n(rst_n), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one AR at a falling edge and hold it until it is accepted (bounded).
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int w = 0;
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!arready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ar_accept", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Wait (bounded) for a beat, check it, then step past its handshake edge.
  task automatic expectBeat(input string tag, input logic [31:0] data, input logic [1:0] resp, input logic last);
    int w = 0;
    while (!rvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_valid"}, 64'(rvalid), 64'd1);
    checkOutput({tag, "_data"}, 64'(rdata), 64'(data));
    checkOutput({tag, "_resp"}, 64'(rresp), 64'(resp));
    checkOutput({tag, "_last"}, 64'(rlast), 64'(last));
    @(negedge clk);
  endtask

  initial begin
    int first;
    int stray;
    int w;
    rst_n = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arburst = '0;
    rready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rlast", 64'(rlast), 64'd0);
    checkOutput("rst_rresp", 64'(rresp), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    checkOutput("rel_arready_same", 64'(arready), 64'd0);
    @(negedge clk);
    checkOutput("rel_arready_next", 64'(arready), 64'd1);

    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = 32'(i);
      @(negedge clk);
    end
    ld_addr = 10'd1023; ld_data = 32'd1023;
    @(negedge clk);
    ld_en = 1'b0;

    // INCR from word 4 with first-beat latency measured in cycles after the AR edge.
    rready = 1'b1;
    araddr = 32'h10; arlen = 8'd3; arburst = 2'd1; arvalid = 1'b1;
    checkOutput("lat_arready", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      if (rvalid) begin
        first = c;
        break;
      end
      @(negedge clk);
    end
    checkOutput("lat_first", 64'(first), 64'd4);
    expectBeat("incr_b0", 32'd4, 2'd0, 1'b0);
    expectBeat("incr_b1", 32'd5, 2'd0, 1'b0);
    expectBeat("incr_b2", 32'd6, 2'd0, 1'b0);
    expectBeat("incr_b3", 32'd7, 2'd0, 1'b1);

    applyStimulus(32'h8, 8'd2, 2'd0);
    expectBeat("fixed_b0", 32'd2, 2'd0, 1'b0);
    expectBeat("fixed_b1", 32'd2, 2'd0, 1'b0);
    expectBeat("fixed_b2", 32'd2, 2'd0, 1'b1);

    // Stall beat 2 of an INCR burst from word 16 for five cycles.
    applyStimulus(32'h40, 8'd3, 2'd1);
    expectBeat("stall_b0", 32'd16, 2'd0, 1'b0);
    rready = 1'b0;
    checkOutput("stall_pre_data", 64'(rdata), 64'd17);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(rvalid), 64'd1);
      checkOutput("stall_data", 64'(rdata), 64'd17);
      checkOutput("stall_last", 64'(rlast), 64'd0);
    end
    rready = 1'b1;
    expectBeat("stall_b1", 32'd17, 2'd0, 1'b0);
    expectBeat("stall_b2", 32'd18, 2'd0, 1'b0);
    expectBeat("stall_b3", 32'd19, 2'd0, 1'b1);

    applyStimulus(32'h13, 8'd0, 2'd1);
    expectBeat("offset", 32'd4, 2'd0, 1'b1);

    applyStimulus(32'hFFC, 8'd1, 2'd1);
    expectBeat("modwrap_b0", 32'd1023, 2'd0, 1'b0);
    expectBeat("modwrap_b1", 32'd0, 2'd0, 1'b1);

    applyStimulus(32'h20, 8'd1, 2'd3);
    expectBeat("rsvd_b0", 32'd0, 2'd2, 1'b0);
    expectBeat("rsvd_b1", 32'd0, 2'd2, 1'b1);

    applyStimulus(32'h18, 8'd3, 2'd2);
`ifdef AXI_RD_WRAP_BURST_EN
    expectBeat("wrap_b0", 32'd6, 2'd0, 1'b0);
    expectBeat("wrap_b1", 32'd7, 2'd0, 1'b0);
    expectBeat("wrap_b2", 32'd4, 2'd0, 1'b0);
    expectBeat("wrap_b3", 32'd5, 2'd0, 1'b1);
`else
    expectBeat("wrap_b0", 32'd0, 2'd2, 1'b0);
    expectBeat("wrap_b1", 32'd0, 2'd2, 1'b0);
    expectBeat("wrap_b2", 32'd0, 2'd2, 1'b0);
    expectBeat("wrap_b3", 32'd0, 2'd2, 1'b1);
`endif
    applyStimulus(32'h18, 8'd2, 2'd2);
    expectBeat("wrapbad_b0", 32'd0, 2'd2, 1'b0);
    expectBeat("wrapbad_b1", 32'd0, 2'd2, 1'b0);
    expectBeat("wrapbad_b2", 32'd0, 2'd2, 1'b1);

    // Preload word 50 on the same edge that fetches it for the second beat.
    rready = 1'b0;
    applyStimulus(32'hC8, 8'd1, 2'd0);
    w = 0;
    while (!rvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ld_b0_valid", 64'(rvalid), 64'd1);
    checkOutput("ld_b0_data", 64'(rdata), 64'd50);
    ld_en = 1'b1; ld_addr = 10'd50; ld_data = 32'hAA; rready = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    expectBeat("ld_old", 32'd50, 2'd0, 1'b1);
    applyStimulus(32'hC8, 8'd0, 2'd0);
    expectBeat("ld_new", 32'hAA, 2'd0, 1'b1);

    // Fill the queue behind a stalled burst, then release it.
    rready = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(32'(4 * k), 8'd0, 2'd1);
    araddr = 32'h18; arlen = 8'd0; arburst = 2'd1; arvalid = 1'b1;
    checkOutput("full_arready", 64'(arready), 64'd0);
    w = 0;
    while (!rvalid && w < 50) begin
      @(negedge clk);
      checkOutput("full_hold", 64'(arready), 64'd0);
      w++;
    end
    checkOutput("full_b0_data", 64'(rdata), 64'd1);
    rready = 1'b1;
    @(negedge clk);
    checkOutput("arready_reopen", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    expectBeat("drain_2", 32'd2, 2'd0, 1'b1);
    expectBeat("drain_3", 32'd3, 2'd0, 1'b1);
    expectBeat("drain_4", 32'd4, 2'd0, 1'b1);
    expectBeat("drain_5", 32'd5, 2'd0, 1'b1);
    expectBeat("drain_6", 32'd6, 2'd0, 1'b1);

    // Reset in the middle of a burst with another burst queued.
    rready = 1'b0;
    applyStimulus(32'h40, 8'd3, 2'd1);
    applyStimulus(32'h80, 8'd0, 2'd1);
    w = 0;
    while (!rvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("mid_b0_data", 64'(rdata), 64'd16);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rvalid", 64'(rvalid), 64'd0);
    checkOutput("mid_arready", 64'(arready), 64'd0);
    checkOutput("mid_rdata", 64'(rdata), 64'd0);
    checkOutput("mid_rlast", 64'(rlast), 64'd0);
    checkOutput("mid_rresp", 64'(rresp), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rel_same", 64'(arready), 64'd0);
    @(negedge clk);
    checkOutput("mid_rel_next", 64'(arready), 64'd1);
    rready = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      if (rvalid) stray++;
      @(negedge clk);
    end
    checkOutput("no_stale", 64'(stray), 64'd0);
    applyStimulus(32'h40, 8'd0, 2'd1);
    expectBeat("mem_kept", 32'd16, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/axi_dram_rd_slave.md
AXI_DRAM_RD_SLAVE -- requirements
Module: axi_dram_rd_slave

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits (power of two, 32..512).
REQ-002 SHALL have parameter AW, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning backing-memory words (power of two).
REQ-004 SHALL have parameter OST, default 4, meaning read-address queue depth (outstanding bursts, power of two, >=2).
REQ-005 SHALL have parameter LAT, default 2, meaning fixed cycles from burst dequeue to first beat (0..15).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (system clock, rising edge) and rst_n input 1 (async active-low reset).
REQ-007 SHALL have port araddr input AW, burst start byte address.
REQ-008 SHALL have port arlen input 8, beats minus one.
REQ-009 SHALL have port arburst input 2, burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-010 SHALL have port arvalid input 1 and port arready output 1, address handshake.
REQ-011 SHALL have ports rvalid output 1 and rready input 1, data handshake with backpressure.
REQ-012 SHALL have ports rdata output DW, rresp output 2 (0 OKAY, 2 SLVERR) and rlast output 1.
REQ-013 SHALL have ports ld_en input 1, ld_addr input log2(DEPTH) and ld_data input DW, a word-indexed preload write port.

Function
REQ-014 AR handshake = arvalid&&arready at a rising edge; it pushes {araddr,arlen,arburst} into an OST-entry FIFO.
REQ-015 arready = !fifo_full (registered or combinational); push and pop in the same cycle SHALL be allowed when full.
REQ-016 FSM states: IDLE, WAIT, BURST.
REQ-017 IDLE: if FIFO non-empty, pop the entry, load the latency counter with LAT, go to WAIT, or to BURST directly if LAT=0.
REQ-018 WAIT: decrement the counter each cycle; at 0, go to BURST.
REQ-019 BURST: rvalid=1 and hold rdata/rresp/rlast stable until rvalid&&rready; after the handshake with rlast=1, go to IDLE.
REQ-020 Latency: an AR handshake in cycle T with empty FIFO and IDLE FSM SHALL give its first rvalid in cycle T+2+LAT.
REQ-021 Word index = (byte address >> log2(DW/8)) mod DEPTH; low byte-offset bits SHALL be ignored.
REQ-022 Beat count SHALL be arlen+1; rlast SHALL be 1 on the final beat only.
REQ-023 FIXED: every beat reads the same index. INCR: index +1 per beat, wrapping modulo DEPTH. Reserved type 3: all beats rresp=2, rdata=0.
REQ-024 Preload: ld_en writes ld_data to mem[ld_addr] at the edge; a same-cycle read of that index SHALL return the old data.
REQ-025 rready low SHALL stall the beat index and outputs with no beat lost or duplicated.

Reset
REQ-026 rst_n low SHALL asynchronously clear the FIFO (empty) and drive arready=0, rvalid=0, rlast=0, rresp=0, rdata=0; the FSM SHALL go to IDLE and the counter to 0.
REQ-027 In-flight and queued bursts SHALL be discarded on reset; memory contents SHALL be retained (not reset).
REQ-028 arready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro AXI_RD_WRAP_BURST_EN defined: WRAP SHALL be supported for arlen in {1,3,7,15}.
REQ-030 WRAP boundary = (arlen+1) words aligned; the index increments and wraps to the aligned base at the boundary; rresp=0.
REQ-031 WRAP with any other arlen SHALL return rresp=2, rdata=0 on all beats.
REQ-032 Macro undefined: every WRAP burst SHALL return rresp=2, rdata=0 for arlen+1 beats; no wrap logic SHALL be present.

Verification
REQ-033 Preload mem[i]=i for i=0..15; INCR araddr=0x10, arlen=3, LAT=2, rready=1 -> beats 4,5,6,7, rlast on the 4th, first rvalid at T+4.
REQ-034 FIXED araddr=0x8, arlen=2 -> three beats of data 2, all rresp=0.
REQ-035 Hold rready=0 for 5 cycles on beat 2 of INCR arlen=3 -> rdata stable throughout; sequence unchanged afterwards.
REQ-036 Issue OST+1 back-to-back ARs with rready=0 -> arready=0 after OST accepted; it rises the cycle after the first burst's last beat pops.
REQ-037 WRAP araddr=0x18 (word 6), arlen=3 -> beats 6,7,4,5 with the macro defined; 4 beats rresp=2 with it undefined.
REQ-038 Assert rst_n=0 mid-burst -> rvalid=0 immediately; after release arready=1 next cycle and no stale beats appear.
